// File: rtl/aib_tx_bert.sv
// aib_tx_bert: transmit-side BERT pattern generator for the AIB adapter TX channel.
// Four generators (PRBS7/15/23/31 or a 128-bit rotating buffer) each emit 1-8 bits
// per clock. Each word is steered onto selected TX lanes and packed into the
// 320-bit TX FIFO word with the same lane/bit map the RX checkers unpack.
// Ports:
//   clk, rstn                  clock, async active-low reset
//   BERT_BUF_MODE_EN           enables the buffer pattern (code 3'b100)
//   tx_rst_pulse/start/err_inj per-generator control pulses
//   genN_ptrn_sel_ff, tx_seedN pattern select and seed/buffer per generator
//   tx_lane_en, tx_lane_gen_sel lane enable and generator select per lane
//   sdr_mode, r_fifo_mode, m_gen2_mode  rate / FIFO ratio / lane mapping
//   tx_bert_data_o             registered packed TX data
//   tbert_bit_cnt_ff           transmitted bit count (wraps)
//   tbert_running_ff           generator running flags
module aib_tx_bert (
  input  logic           clk,
  input  logic           rstn,
  input  logic           BERT_BUF_MODE_EN,
  input  logic [3:0]     tx_rst_pulse,
  input  logic [3:0]     tx_start_pulse,
  input  logic [3:0]     tx_err_inj_pulse,
  input  logic [2:0]     gen3_ptrn_sel_ff,
  input  logic [2:0]     gen2_ptrn_sel_ff,
  input  logic [2:0]     gen1_ptrn_sel_ff,
  input  logic [2:0]     gen0_ptrn_sel_ff,
  input  logic [127:0]   tx_seed3,
  input  logic [127:0]   tx_seed2,
  input  logic [127:0]   tx_seed1,
  input  logic [127:0]   tx_seed0,
  input  logic [39:0]    tx_lane_en,
  input  logic [79:0]    tx_lane_gen_sel,
  input  logic           sdr_mode,
  input  logic [1:0]     r_fifo_mode,
  input  logic           m_gen2_mode,
  output logic [319:0]   tx_bert_data_o,
  output logic [48:0]    tbert_bit_cnt_ff,
  output logic [3:0]     tbert_running_ff
);

  localparam int unsigned NUM_GEN  = 4;
  localparam int unsigned NUM_LANE = 40;
  localparam int unsigned GEN1_LN  = 20;
  localparam int unsigned DATA_W   = 320;
  localparam int unsigned CNT_W    = 49;
  localparam int unsigned PAT_W    = 128;
  localparam int unsigned WORD_W   = 8;

  logic [NUM_GEN-1:0]  running_q, running_d;
  logic [NUM_GEN-1:0]  err_q, err_d;
  logic [2:0]          ptrn_q  [NUM_GEN];
  logic [2:0]          ptrn_d  [NUM_GEN];
  logic [PAT_W-1:0]    state_q [NUM_GEN];
  logic [PAT_W-1:0]    state_d [NUM_GEN];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [3:0]          nb_c;
  logic [2:0]          sel_c   [NUM_GEN];
  logic [PAT_W-1:0]    seed_c  [NUM_GEN];
  logic [WORD_W-1:0]   word_c  [NUM_GEN];
  logic [PAT_W-1:0]    adv_c   [NUM_GEN];

  // PRBS polynomial parameters: register mask, output bit index, lower tap index
  function automatic logic [31:0] prbs_mask(input logic [2:0] p);
    case (p[1:0])
      2'd0:    return 32'h0000_007F;
      2'd1:    return 32'h0000_7FFF;
      2'd2:    return 32'h007F_FFFF;
      default: return 32'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic [4:0] prbs_msb(input logic [2:0] p);
    case (p[1:0])
      2'd0:    return 5'd6;
      2'd1:    return 5'd14;
      2'd2:    return 5'd22;
      default: return 5'd30;
    endcase
  endfunction

  function automatic logic [4:0] prbs_tap(input logic [2:0] p);
    case (p[1:0])
      2'd0:    return 5'd5;
      2'd1:    return 5'd13;
      2'd2:    return 5'd17;
      default: return 5'd27;
    endcase
  endfunction

  function automatic logic [PAT_W-1:0] rot_right(input logic [PAT_W-1:0] p,
                                                  input logic [3:0] n);
    case (n)
      4'd2:    return {p[1:0], p[PAT_W-1:2]};
      4'd4:    return {p[3:0], p[PAT_W-1:4]};
      4'd8:    return {p[7:0], p[PAT_W-1:8]};
      default: return {p[0],   p[PAT_W-1:1]};
    endcase
  endfunction

  // Bits per clock from FIFO ratio and data rate; register mode behaves as 1:1
  always_comb begin : nb_sel
    nb_c = 4'd1;
    case (r_fifo_mode)
      2'b01:   nb_c = sdr_mode ? 4'd2 : 4'd4;
      2'b10:   nb_c = sdr_mode ? 4'd4 : 4'd8;
      default: nb_c = sdr_mode ? 4'd1 : 4'd2;
    endcase
  end

  always_comb begin : in_map
    sel_c[0]  = gen0_ptrn_sel_ff;
    sel_c[1]  = gen1_ptrn_sel_ff;
    sel_c[2]  = gen2_ptrn_sel_ff;
    sel_c[3]  = gen3_ptrn_sel_ff;
    seed_c[0] = tx_seed0;
    seed_c[1] = tx_seed1;
    seed_c[2] = tx_seed2;
    seed_c[3] = tx_seed3;
  end

  // Per-generator word for this clock and the state it advances to
  always_comb begin : gen_word
    logic [31:0]      s;
    logic [31:0]      mask;
    logic [4:0]       msb;
    logic [4:0]       tap;
    logic             fb;
    logic [PAT_W-1:0] p;
    for (int g = 0; g < NUM_GEN; g++) begin
      word_c[g] = '0;
      adv_c[g]  = state_q[g];
      mask      = prbs_mask(ptrn_q[g]);
      msb       = prbs_msb(ptrn_q[g]);
      tap       = prbs_tap(ptrn_q[g]);
      s         = state_q[g][31:0] & mask;
      p         = state_q[g];
      fb        = 1'b0;
      if (!ptrn_q[g][2]) begin
        for (int k = 0; k < WORD_W; k++) begin
          if (k < int'(nb_c)) begin
            word_c[g][k] = s[msb];
            fb           = s[msb] ^ s[tap];
            s            = ((s << 1) | 32'(fb)) & mask;
          end
        end
        adv_c[g] = {96'd0, s};
      end else if (ptrn_q[g] == 3'b100) begin
        for (int k = 0; k < WORD_W; k++) begin
          if (k < int'(nb_c) && BERT_BUF_MODE_EN) word_c[g][k] = p[k];
        end
        adv_c[g] = rot_right(p, nb_c);
      end
      if (!running_q[g]) begin
        word_c[g] = '0;
        adv_c[g]  = state_q[g];
      end else if (err_q[g]) begin
        // Injected error flips only the first bit on the wire; LFSR untouched
        word_c[g][0] = ~word_c[g][0];
      end
    end
  end

  // Generator control: start loads seed, rst overrides start
  always_comb begin : gen_ctrl
    logic [31:0] m;
    logic [31:0] v;
    m = '0;
    v = '0;
    for (int g = 0; g < NUM_GEN; g++) begin
      running_d[g] = running_q[g];
      ptrn_d[g]    = ptrn_q[g];
      state_d[g]   = adv_c[g];
      err_d[g]     = tx_err_inj_pulse[g] & running_q[g];
      if (tx_start_pulse[g]) begin
        running_d[g] = 1'b1;
        ptrn_d[g]    = sel_c[g];
        err_d[g]     = 1'b0;
        if (!sel_c[g][2]) begin
          m = prbs_mask(sel_c[g]);
          v = seed_c[g][31:0] & m;
          // An all-zero LFSR would lock up; substitute all ones
          if (v == 32'd0) v = m;
          state_d[g] = {96'd0, v};
        end else begin
          state_d[g] = seed_c[g];
        end
      end
      if (tx_rst_pulse[g]) begin
        running_d[g] = 1'b0;
        state_d[g]   = '0;
        err_d[g]     = 1'b0;
      end
    end
  end

  // Lane steering and packing into the TX FIFO word
  always_comb begin : pack
    logic [WORD_W-1:0] w;
    data_d = '0;
    w      = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      w = tx_lane_en[i] ? word_c[tx_lane_gen_sel[2*i +: 2]] : '0;
      if (m_gen2_mode) begin
        data_d[2*i]       = w[0];
        data_d[2*i+1]     = w[1];
        data_d[2*i+80]    = w[2];
        data_d[2*i+81]    = w[3];
        data_d[2*i+160]   = w[4];
        data_d[2*i+161]   = w[5];
        data_d[2*i+240]   = w[6];
        data_d[2*i+241]   = w[7];
      end else if (i < GEN1_LN) begin
        if (sdr_mode) begin
          data_d[2*i]     = w[0];
          data_d[2*i+40]  = w[1];
        end else begin
          data_d[2*i]     = w[0];
          data_d[2*i+1]   = w[1];
          data_d[2*i+40]  = w[2];
          data_d[2*i+41]  = w[3];
        end
      end
    end
  end

  // Transmitted-bit counter
  always_comb begin : bit_cnt
    cnt_d = cnt_q;
    if (|tx_rst_pulse)   cnt_d = '0;
    else if (|running_q) cnt_d = cnt_q + CNT_W'(nb_c);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      running_q <= '0;
      err_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      for (int g = 0; g < NUM_GEN; g++) begin
        ptrn_q[g]  <= '0;
        state_q[g] <= '0;
      end
    end else begin
      running_q <= running_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      for (int g = 0; g < NUM_GEN; g++) begin
        ptrn_q[g]  <= ptrn_d[g];
        state_q[g] <= state_d[g];
      end
    end
  end

  assign tx_bert_data_o   = data_q;
  assign tbert_bit_cnt_ff = cnt_q;
  assign tbert_running_ff = running_q;

endmodule

// File: tb/tb_aib_tx_bert.sv
// Directed bench for aib_tx_bert: table of packing/rate vectors plus
// hand-written multi-cycle sequences (PRBS7, buffer wrap, error injection,
// start/rst collision, buffer disable, counter wrap, async reset).
module tb_aib_tx_bert;

  logic           clk = 1'b0;
  logic           rstn;
  logic           BERT_BUF_MODE_EN;
  logic [3:0]     tx_rst_pulse, tx_start_pulse, tx_err_inj_pulse;
  logic [2:0]     gen3_ptrn_sel_ff, gen2_ptrn_sel_ff, gen1_ptrn_sel_ff, gen0_ptrn_sel_ff;
  logic [127:0]   tx_seed3, tx_seed2, tx_seed1, tx_seed0;
  logic [39:0]    tx_lane_en;
  logic [79:0]    tx_lane_gen_sel;
  logic           sdr_mode;
  logic [1:0]     r_fifo_mode;
  logic           m_gen2_mode;
  logic [319:0]   tx_bert_data_o;
  logic [48:0]    tbert_bit_cnt_ff;
  logic [3:0]     tbert_running_ff;

  always #5 clk = ~clk;

  aib_tx_bert dut (
    .clk              (clk),
    .rstn             (rstn),
    .BERT_BUF_MODE_EN (BERT_BUF_MODE_EN),
    .tx_rst_pulse     (tx_rst_pulse),
    .tx_start_pulse   (tx_start_pulse),
    .tx_err_inj_pulse (tx_err_inj_pulse),
    .gen3_ptrn_sel_ff (gen3_ptrn_sel_ff),
    .gen2_ptrn_sel_ff (gen2_ptrn_sel_ff),
    .gen1_ptrn_sel_ff (gen1_ptrn_sel_ff),
    .gen0_ptrn_sel_ff (gen0_ptrn_sel_ff),
    .tx_seed3         (tx_seed3),
    .tx_seed2         (tx_seed2),
    .tx_seed1         (tx_seed1),
    .tx_seed0         (tx_seed0),
    .tx_lane_en       (tx_lane_en),
    .tx_lane_gen_sel  (tx_lane_gen_sel),
    .sdr_mode         (sdr_mode),
    .r_fifo_mode      (r_fifo_mode),
    .m_gen2_mode      (m_gen2_mode),
    .tx_bert_data_o   (tx_bert_data_o),
    .tbert_bit_cnt_ff (tbert_bit_cnt_ff),
    .tbert_running_ff (tbert_running_ff)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam logic [9:0] NONE = 10'h3FF;

  // One packing vector: mode, lane, bits per clock, data bit for w[k]
  typedef struct packed {
    logic           gen2;
    logic           sdr;
    logic [1:0]     fmode;
    logic [5:0]     lane;
    logic [3:0]     nb;
    logic [7:0][9:0] pos;
  } vec_t;

  function automatic vec_t mk(input logic g2, input logic sd, input logic [1:0] fm,
                              input int ln, input int n,
                              input int p0, input int p1, input int p2, input int p3,
                              input int p4, input int p5, input int p6, input int p7);
    vec_t v;
    int   p [8];
    p = '{p0, p1, p2, p3, p4, p5, p6, p7};
    v.gen2  = g2;
    v.sdr   = sd;
    v.fmode = fm;
    v.lane  = 6'(ln);
    v.nb    = 4'(n);
    for (int k = 0; k < 8; k++) v.pos[k] = (p[k] < 0) ? NONE : 10'(p[k]);
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic gen_rst(input logic [3:0] m);
    @(negedge clk) tx_rst_pulse = m;
    @(negedge clk) tx_rst_pulse = 4'h0;
  endtask

  task automatic gen_start(input logic [3:0] m);
    @(negedge clk) tx_start_pulse = m;
    @(negedge clk) tx_start_pulse = 4'h0;
  endtask

  vec_t          vecs [9];
  logic [7:0]    pat;
  logic [319:0]  exp_d;
  logic [7:0]    prbs7_exp;
  logic [7:0]    got_b;
  logic [30:0]   ps;
  logic [1:0]    gw;
  logic [1:0]    gw_f;
  int            diffs;

  initial begin
    // Table: w[0] first; -1 = bit not mapped in that mode
    vecs[0] = mk(1, 0, 2'b10,  3, 8,   6,   7, 86, 87, 166, 167, 246, 247);
    vecs[1] = mk(1, 1, 2'b10,  0, 4,   0,   1, 80, 81, 160, 161, 240, 241);
    vecs[2] = mk(1, 0, 2'b00, 39, 2,  78,  79,158,159, 238, 239, 318, 319);
    vecs[3] = mk(0, 0, 2'b01,  5, 4,  10,  11, 50, 51,  -1,  -1,  -1,  -1);
    vecs[4] = mk(0, 1, 2'b00, 19, 1,  38,  78, -1, -1,  -1,  -1,  -1,  -1);
    vecs[5] = mk(0, 1, 2'b01,  2, 2,   4,  44, -1, -1,  -1,  -1,  -1,  -1);
    vecs[6] = mk(0, 0, 2'b10,  7, 8,  14,  15, 54, 55,  -1,  -1,  -1,  -1);
    vecs[7] = mk(0, 0, 2'b11, 25, 2,  -1,  -1, -1, -1,  -1,  -1,  -1,  -1);
    vecs[8] = mk(1, 0, 2'b11, 10, 2,  20,  21,100,101, 180, 181, 260, 261);

    rstn = 1'b0;
    BERT_BUF_MODE_EN = 1'b1;
    tx_rst_pulse = '0; tx_start_pulse = '0; tx_err_inj_pulse = '0;
    gen3_ptrn_sel_ff = '0; gen2_ptrn_sel_ff = '0; gen1_ptrn_sel_ff = '0; gen0_ptrn_sel_ff = '0;
    tx_seed3 = '0; tx_seed2 = '0; tx_seed1 = '0; tx_seed0 = '0;
    tx_lane_en = '0; tx_lane_gen_sel = '0;
    sdr_mode = 1'b0; r_fifo_mode = 2'b00; m_gen2_mode = 1'b0;

    tick(); tick();
    chk("reset_data", tx_bert_data_o, '0);
    chk("reset_cnt", 320'(tbert_bit_cnt_ff), '0);
    chk("reset_running", 320'(tbert_running_ff), '0);
    rstn = 1'b1;
    tick();

    // Packing / rate table, gen0 buffer pattern
    pat = 8'hB7;
    for (int v = 0; v < 9; v++) begin
      m_gen2_mode      = vecs[v].gen2;
      sdr_mode         = vecs[v].sdr;
      r_fifo_mode      = vecs[v].fmode;
      tx_lane_en       = 40'd1 << vecs[v].lane;
      tx_lane_gen_sel  = '0;
      gen0_ptrn_sel_ff = 3'b100;
      tx_seed0         = {120'd0, pat};
      gen_rst(4'hF);
      gen_start(4'h1);
      tick();
      exp_d = '0;
      for (int k = 0; k < 8; k++)
        if (vecs[v].pos[k] != NONE && k < int'(vecs[v].nb)) exp_d[vecs[v].pos[k]] = pat[k];
      chk($sformatf("vec%0d_data", v), tx_bert_data_o, exp_d);
      chk($sformatf("vec%0d_cnt", v), 320'(tbert_bit_cnt_ff), 320'(vecs[v].nb));
    end

    // PRBS7 from zero seed, GEN1 SDR 1:1, lane 0
    m_gen2_mode = 1'b0; sdr_mode = 1'b1; r_fifo_mode = 2'b00;
    tx_lane_en = 40'd1; tx_lane_gen_sel = '0;
    gen0_ptrn_sel_ff = 3'b000; tx_seed0 = '0;
    gen_rst(4'hF);
    gen_start(4'h1);
    prbs7_exp = 8'b0111_1111;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("prbs7_bit%0d", j), 320'(tx_bert_data_o[0]), 320'(prbs7_exp[j]));
    end
    chk("prbs7_cnt", 320'(tbert_bit_cnt_ff), 320'd8);
    chk("prbs7_running", 320'(tbert_running_ff), 320'h1);

    // Buffer on gen1, GEN2 DDR 1:4, lane 3; 128-bit pattern repeats every 16 words
    m_gen2_mode = 1'b1; sdr_mode = 1'b0; r_fifo_mode = 2'b10;
    tx_lane_en = 40'd1 << 3; tx_lane_gen_sel = 80'h40;
    gen1_ptrn_sel_ff = 3'b100; tx_seed1 = {112'd0, 8'h3C, 8'hA5};
    gen_rst(4'hF);
    gen_start(4'h2);
    for (int j = 1; j <= 18; j++) begin
      tick();
      got_b = {tx_bert_data_o[247], tx_bert_data_o[246], tx_bert_data_o[167], tx_bert_data_o[166],
               tx_bert_data_o[87],  tx_bert_data_o[86],  tx_bert_data_o[7],   tx_bert_data_o[6]};
      if (j == 1 || j == 17) chk($sformatf("buf_word%0d", j), 320'(got_b), 320'h A5);
      if (j == 2 || j == 18) chk($sformatf("buf_word%0d", j), 320'(got_b), 320'h3C);
      if (j == 3)            chk("buf_word3", 320'(got_b), 320'h0);
    end
    chk("buf_cnt", 320'(tbert_bit_cnt_ff), 320'd144);

    // PRBS31 on gen2 with one injected error, GEN2 DDR 1:1, lane 0
    m_gen2_mode = 1'b1; sdr_mode = 1'b0; r_fifo_mode = 2'b00;
    tx_lane_en = 40'd1; tx_lane_gen_sel = 80'h2;
    gen2_ptrn_sel_ff = 3'b011; tx_seed2 = 128'h1234_5678;
    gen_rst(4'hF);
    gen_start(4'h4);
    ps = 31'h1234_5678;
    diffs = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        gw[k] = ps[30];
        ps    = {ps[29:0], ps[30] ^ ps[27]};
      end
      gw_f = (j == 5) ? (gw ^ 2'b01) : gw;
      if (tx_bert_data_o[0] !== gw[0]) diffs++;
      if (tx_bert_data_o[1] !== gw[1]) diffs++;
      chk($sformatf("prbs31_word%0d", j), 320'(tx_bert_data_o[1:0]), 320'(gw_f));
      tx_err_inj_pulse = (j == 3) ? 4'b0100 : 4'b0000;
    end
    chk("prbs31_flip_count", 320'(diffs), 320'd1);

    // Start and rst together on gen3: rst wins
    tx_lane_gen_sel = 80'h3;
    gen3_ptrn_sel_ff = 3'b100; tx_seed3 = '1;
    gen_rst(4'hF);
    @(negedge clk) begin tx_start_pulse = 4'h8; tx_rst_pulse = 4'h8; end
    @(negedge clk) begin tx_start_pulse = 4'h0; tx_rst_pulse = 4'h0; end
    tick(); tick();
    chk("collide_running", 320'(tbert_running_ff), '0);
    chk("collide_data", tx_bert_data_o, '0);
    chk("collide_cnt", 320'(tbert_bit_cnt_ff), '0);

    // Buffer disabled: runs but emits zeros; codes 101-111 emit zeros
    BERT_BUF_MODE_EN = 1'b0;
    tx_lane_gen_sel = '0;
    gen0_ptrn_sel_ff = 3'b100; tx_seed0 = '1;
    gen_rst(4'hF);
    gen_start(4'h1);
    tick();
    chk("bufdis_running", 320'(tbert_running_ff), 320'h1);
    chk("bufdis_data", tx_bert_data_o, '0);
    gen0_ptrn_sel_ff = 3'b111;
    gen_start(4'h1);
    tick();
    chk("ptrn111_running", 320'(tbert_running_ff), 320'h1);
    chk("ptrn111_data", tx_bert_data_o, '0);
    BERT_BUF_MODE_EN = 1'b1;
    gen0_ptrn_sel_ff = 3'b100;
    gen_start(4'h1);
    tick();
    chk("bufen_data", 320'(tx_bert_data_o[1:0]), 320'h3);

    // Counter wrap at nb = 8, then async reset mid-run
    r_fifo_mode = 2'b10;
    force dut.cnt_q = 49'h1_FFFF_FFFF_FFFC;
    #1;
    release dut.cnt_q;
    tick();
    chk("cnt_wrap", 320'(tbert_bit_cnt_ff), 320'h4);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_data", tx_bert_data_o, '0);
    chk("async_rst_cnt", 320'(tbert_bit_cnt_ff), '0);
    chk("async_rst_running", 320'(tbert_running_ff), '0);
    @(negedge clk) rstn = 1'b1;
    tick(); tick();
    chk("after_rst_data", tx_bert_data_o, '0);
    chk("after_rst_running", 320'(tbert_running_ff), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aib_tx_bert.md
# aib_tx_bert

Transmit-side BERT pattern generator for the AIB adapter TX channel. Four independent generators (PRBS7/15/23/31 or a 128-bit repeating buffer) produce 1–8 bits per clock. Each bit word is steered onto any subset of the 40 TX lanes and packed into the 320-bit TX FIFO data word, using the same lane/bit mapping the RX BERT checkers unpack. A 49-bit transmitted-bit counter runs alongside the generators.

## Interface
- BERT_BUF_MODE_EN, 1, enables buffer pattern (ptrn 3'b100); when 0, that code produces zeros
- clk  in  1  TX BERT clock
- rstn  in  1  asynchronous active-low reset
- tx_rst_pulse  in  4  per-generator synchronous reset; any bit set also clears the bit counter
- tx_start_pulse  in  4  per-generator start
- tx_err_inj_pulse  in  4  per-generator single-bit error injection
- gen3_ptrn_sel_ff … gen0_ptrn_sel_ff  in  3 each  pattern select
- tx_seed3 … tx_seed0  in  128 each  PRBS seed (low N bits) or buffer pattern
- tx_lane_en  in  40  lane i driven by BERT when set
- tx_lane_gen_sel  in  80  bits [2i+1:2i] = generator feeding lane i
- sdr_mode  in  1  single data rate
- r_fifo_mode  in  2  00 1:1, 01 1:2, 10 1:4, 11 register (treated as 00)
- m_gen2_mode  in  1  GEN2 lane mapping
- tx_bert_data_o  out  320  packed TX data, registered
- tbert_bit_cnt_ff  out  49  transmitted bit count
- tbert_running_ff  out  4  generator running flags

## Operation
- Bits per clock (nb): 1:1 SDR→1, DDR→2; 1:2 SDR→2, DDR→4; 1:4 SDR→4, DDR→8; 11 same as 1:1.
- Pattern codes: 000 PRBS7 (x^7+x^6+1), 001 PRBS15 (x^15+x^14+1), 010 PRBS23 (x^23+x^18+1), 011 PRBS31 (x^31+x^28+1), 100 buffer, 101–111 zeros.
- PRBS step, N-bit state s: out = s[N-1], s <= {s[N-2:0], s[N-1]^s[T-1]}, where T is the lower tap. nb steps per clock; word w[k] = k-th output bit (w[0] first on the wire); w[7:nb] = 0.
- Buffer: register p[127:0]; w[nb-1:0] = p[nb-1:0]; p rotates right by nb each clock.
- Start pulse: latch ptrn_sel, load state from seed; an all-zero PRBS seed is loaded as all-ones. Set running. Start while running restarts from the seed.
- Rst pulse: clear running, zero state. Rst wins over simultaneous start on the same generator.
- Error injection: if running, invert w[0] of the next generated word only. The LFSR state is unaffected.
- Generator not running → word 0.
- Lane i word = tx_lane_en[i] ? w of gen tx_lane_gen_sel[2i+1:2i] : 0.
- Packing, GEN2: w[7:0] → bits {2i+241, 2i+240, 2i+161, 2i+160, 2i+81, 2i+80, 2i+1, 2i}.
- Packing, GEN1 (lanes 0–19 only):
  - DDR: w[3:0] → {2i+41, 2i+40, 2i+1, 2i}.
  - SDR: w[1:0] → {2i+40, 2i}.
  - All other bits 0; lanes 20–39 ignored.
- Bit counter: cleared by rstn or any tx_rst_pulse bit; else +nb per clock while any running bit is set; wraps mod 2^49.

## Timing
- Reset values: tx_bert_data_o = 0, tbert_bit_cnt_ff = 0, tbert_running_ff = 0, all generator state 0.
- Start sampled at edge E0 → running = 1 after E0. The first word appears on tx_bert_data_o after E1, and the state advances at E1.
- Counter first increments at E1.
- Rst sampled at edge E → running = 0 after E; tx_bert_data_o for that generator = 0 after E+1.
- Error pulse sampled at E → inverted bit appears on tx_bert_data_o after E+1, for exactly one cycle.
- Lane enable/select and mode inputs are combinational into the output register (1-cycle latency). They are quasi-static during a run.
- Async rstn mid-run clears everything immediately; a new start is required.

## Test plan
- GEN1 SDR 1:1, gen0 PRBS7, seed 0, lane 0 enabled → serial bit 0 over 8 cycles = 1,1,1,1,1,1,1,0; tbert_bit_cnt_ff = 8.
- GEN2 DDR 1:4, gen1 buffer, seed low byte 8'hA5 then 8'h3C, lane 3 → word 1 on bits {247, 246, 167, 166, 87, 86, 7, 6} = A5; word 2 = 3C; after 16 cycles the pattern repeats; count +8 per clock.
- Gen2 PRBS31 running, tx_err_inj_pulse[2] for one cycle → exactly one bit flipped vs the golden model; following words match.
- Simultaneous start and rst on gen3 → running stays 0, output 0, counter 0.
- BERT_BUF_MODE_EN = 0, ptrn 100 → running = 1, output all zeros; ptrn 111 → zeros.
- Wrap: counter preloaded near max by a long run (or forced) at 49'h1_FFFF_FFFF_FFFC with nb = 8 → 49'h4; rstn low mid-run → all outputs 0.
